// File: rtl/rvfi_chk_pkg.sv
// Shared constants for the RVFI commit checker: error-class bit positions and marker/halt encodings.
// No logic; no latency or backpressure.
package rvfi_chk_pkg;

  localparam int ERR_PACK     = 0;
  localparam int ERR_ORDER    = 1;
  localparam int ERR_PC       = 2;
  localparam int ERR_TIMEOUT  = 3;
  localparam int ERR_POSTHALT = 4;
  localparam int NUM_ERR      = 5;

  localparam logic [31:0] INST_START    = 32'h00102013;
  localparam logic [31:0] INST_STOP     = 32'h00202013;
  localparam logic [31:0] INST_BEQ_SELF = 32'h00000063;
  localparam logic [31:0] INST_JAL_SELF = 32'h0000006f;

endpackage

// File: rtl/rvfi_chk_lane.sv
// Per-lane classifier: flags self-loop halts and measurement start/stop markers.
// Purely combinational, zero latency; no backpressure.
module rvfi_chk_lane
  import rvfi_chk_pkg::*;
(
  input  logic [31:0] inst,
  input  logic [31:0] pc_rdata,
  input  logic [31:0] pc_wdata,
  output logic        is_halt,
  output logic        is_start,
  output logic        is_stop
);

  assign is_halt  = (pc_rdata == pc_wdata) || (inst == INST_BEQ_SELF) || (inst == INST_JAL_SELF);
  assign is_start = (inst == INST_START);
  assign is_stop  = (inst == INST_STOP);

endmodule

// File: rtl/rvfi_commit_checker.sv
// Multi-lane RVFI commit checker: packing/order/PC-chain/halt/watchdog checks plus a marker-bounded perf window.
// Latency: every output registered, one cycle after the sampled commit; observes only, never backpressures.
module rvfi_commit_checker
  import rvfi_chk_pkg::*;
#(
  parameter int NRET    = 2,
  parameter int CNT_W   = 64,
  parameter int TIMEOUT = 10000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NRET-1:0]            valid,
  input  logic [NRET-1:0][CNT_W-1:0] order,
  input  logic [NRET-1:0][31:0]      inst,
  input  logic [NRET-1:0][31:0]      pc_rdata,
  input  logic [NRET-1:0][31:0]      pc_wdata,
  output logic                       halt,
  output logic                       error,
  output logic [7:0]                 errcode,
  output logic [CNT_W-1:0]           first_err_order,
  output logic [CNT_W-1:0]           inst_count,
  output logic [CNT_W-1:0]           cycle_count,
  output logic                       window_done
);

  localparam int KW = $clog2(NRET + 1);
  localparam bit WD_EN = (TIMEOUT > 0);
  localparam int WD_W = WD_EN ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(WD_EN ? TIMEOUT : 0);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_EN ? TIMEOUT - 1 : 0);

  logic [NRET-1:0] lane_halt;
  logic [NRET-1:0] lane_start;
  logic [NRET-1:0] lane_stop;

  for (genvar g = 0; g < NRET; g++) begin : g_lane
    rvfi_chk_lane u_lane (
      .inst     (inst[g]),
      .pc_rdata (pc_rdata[g]),
      .pc_wdata (pc_wdata[g]),
      .is_halt  (lane_halt[g]),
      .is_start (lane_start[g]),
      .is_stop  (lane_stop[g])
    );
  end

  logic [CNT_W-1:0]   exp_order;
  logic [31:0]        last_pc;
  logic               pc_known;
  logic [WD_W-1:0]    wd_cnt;
  logic [NUM_ERR-1:0] err_q;

  logic [NRET-1:0]    in_pfx, pack_bad, order_bad, pc_bad, post_bad, offend;
  logic [KW-1:0]      k;
  logic               pfx_open, halt_seen, commit, halt_now, start_hit, stop_hit, tmo_hit;
  logic [CNT_W-1:0]   last_order, feo_src;
  logic [31:0]        last_wdata;
  logic [NUM_ERR-1:0] new_err;

  always_comb begin
    in_pfx   = '0;
    k        = '0;
    pfx_open = 1'b1;
    for (int i = 0; i < NRET; i++) begin
      if (valid[i] && pfx_open) begin
        in_pfx[i] = 1'b1;
        k         = KW'(i + 1);
      end else begin
        pfx_open = 1'b0;
      end
    end
    commit   = in_pfx[0];
    pack_bad = valid & ~in_pfx;

    order_bad  = '0;
    pc_bad     = '0;
    post_bad   = '0;
    halt_seen  = 1'b0;
    last_order = exp_order;
    last_wdata = last_pc;
    pc_bad[0]  = in_pfx[0] && pc_known && (pc_rdata[0] != last_pc);
    for (int i = 1; i < NRET; i++) begin
      pc_bad[i] = in_pfx[i] && (pc_rdata[i] != pc_wdata[i-1]);
    end
    // Lanes behind a halting lane, or any commit after halt, are post-halt violations.
    for (int i = 0; i < NRET; i++) begin
      order_bad[i] = in_pfx[i] && (order[i] != exp_order + CNT_W'(i));
      post_bad[i]  = valid[i] && (halt_seen || (halt && in_pfx[i]));
      if (in_pfx[i] && lane_halt[i]) halt_seen = 1'b1;
      if (in_pfx[i]) begin
        last_order = order[i];
        last_wdata = pc_wdata[i];
      end
    end

    halt_now  = |(in_pfx & lane_halt);
    start_hit = |(in_pfx & lane_start);
    stop_hit  = |(in_pfx & lane_stop);
    tmo_hit   = WD_EN && !commit && !halt && (wd_cnt == WD_LAST);

    new_err               = '0;
    new_err[ERR_PACK]     = |pack_bad;
    new_err[ERR_ORDER]    = |order_bad;
    new_err[ERR_PC]       = |pc_bad;
    new_err[ERR_TIMEOUT]  = tmo_hit;
    new_err[ERR_POSTHALT] = |post_bad;

    // Lane offenders win over the watchdog; descending scan leaves the lowest lane.
    offend  = pack_bad | order_bad | pc_bad | post_bad;
    feo_src = exp_order;
    for (int i = NRET - 1; i >= 0; i--) begin
      if (offend[i]) feo_src = order[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q           <= '0;
      halt            <= 1'b0;
      first_err_order <= '0;
      exp_order       <= '0;
      last_pc         <= '0;
      pc_known        <= 1'b0;
      wd_cnt          <= '0;
      inst_count      <= '0;
      cycle_count     <= '0;
      window_done     <= 1'b0;
    end else begin
      err_q <= err_q | new_err;
      if (!(|err_q) && (|new_err)) first_err_order <= feo_src;
      if (halt_now) halt <= 1'b1;

      if (commit) begin
        exp_order <= last_order + CNT_W'(1);
        last_pc   <= last_wdata;
        pc_known  <= 1'b1;
        wd_cnt    <= '0;
      end else if (WD_EN && !halt && (wd_cnt != WD_MAX)) begin
        wd_cnt <= wd_cnt + WD_W'(1);
      end

      if (start_hit) begin
        cycle_count <= '0;
        inst_count  <= '0;
        window_done <= 1'b0;
      end else if (!window_done) begin
        cycle_count <= cycle_count + CNT_W'(1);
        inst_count  <= inst_count + CNT_W'(k);
        if (stop_hit) window_done <= 1'b1;
      end
    end
  end

  assign errcode = {{(8 - NUM_ERR){1'b0}}, err_q};
  assign error   = |err_q;

endmodule

// File: tb/tb_rvfi_commit_checker.sv
// Directed bench for rvfi_commit_checker (NRET=2, TIMEOUT=20); expectations queued at drive time, checked one edge later.
module tb_rvfi_commit_checker;

  localparam int NRET  = 2;
  localparam int CNT_W = 64;
  localparam int TMO   = 20;
  localparam logic [31:0] NOP   = 32'h00000013;
  localparam logic [31:0] START = 32'h00102013;
  localparam logic [31:0] STOP  = 32'h00202013;
  localparam logic [31:0] JALS  = 32'h0000006f;

  logic                       clk = 1'b0;
  logic                       rst;
  logic [NRET-1:0]            valid;
  logic [NRET-1:0][CNT_W-1:0] order;
  logic [NRET-1:0][31:0]      inst;
  logic [NRET-1:0][31:0]      pc_rdata;
  logic [NRET-1:0][31:0]      pc_wdata;
  logic                       halt;
  logic                       error;
  logic [7:0]                 errcode;
  logic [CNT_W-1:0]           first_err_order;
  logic [CNT_W-1:0]           inst_count;
  logic [CNT_W-1:0]           cycle_count;
  logic                       window_done;

  always #5 clk = ~clk;

  rvfi_commit_checker #(.NRET(NRET), .CNT_W(CNT_W), .TIMEOUT(TMO)) dut (
    .clk             (clk),
    .rst             (rst),
    .valid           (valid),
    .order           (order),
    .inst            (inst),
    .pc_rdata        (pc_rdata),
    .pc_wdata        (pc_wdata),
    .halt            (halt),
    .error           (error),
    .errcode         (errcode),
    .first_err_order (first_err_order),
    .inst_count      (inst_count),
    .cycle_count     (cycle_count),
    .window_done     (window_done)
  );

  typedef struct {
    logic [7:0]  ec;
    logic        h;
    bit          do_feo;
    logic [63:0] feo;
    bit          do_cnt;
    logic [63:0] ic;
    logic [63:0] cc;
    logic        wdn;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  logic [63:0] nxt_order;
  logic [31:0] nxt_pc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic expect_state(input string tag, input logic [7:0] ec, input logic h,
                              input bit do_feo, input logic [63:0] feo,
                              input bit do_cnt, input logic [63:0] ic, input logic [63:0] cc,
                              input logic wdn);
    exp_t e;
    e.ec = ec; e.h = h; e.do_feo = do_feo; e.feo = feo;
    e.do_cnt = do_cnt; e.ic = ic; e.cc = cc; e.wdn = wdn;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic tick();
    exp_t  e;
    string t;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      chk({t, ".errcode"}, 64'(errcode), 64'(e.ec));
      chk({t, ".error"}, 64'(error), 64'(|e.ec));
      chk({t, ".halt"}, 64'(halt), 64'(e.h));
      chk({t, ".window_done"}, 64'(window_done), 64'(e.wdn));
      if (e.do_feo) chk({t, ".first_err_order"}, first_err_order, e.feo);
      if (e.do_cnt) begin
        chk({t, ".inst_count"}, inst_count, e.ic);
        chk({t, ".cycle_count"}, cycle_count, e.cc);
      end
    end
  endtask

  task automatic drive_idle();
    valid       = '0;
    order       = '0;
    inst[0]     = NOP;
    inst[1]     = NOP;
    pc_rdata    = '0;
    pc_wdata[0] = 32'h4;
    pc_wdata[1] = 32'h4;
  endtask

  task automatic drive_c1(input logic [31:0] ins);
    drive_idle();
    valid[0]    = 1'b1;
    order[0]    = nxt_order;
    inst[0]     = ins;
    pc_rdata[0] = nxt_pc;
    pc_wdata[0] = nxt_pc + 32'd4;
    nxt_order   = nxt_order + 64'd1;
    nxt_pc      = nxt_pc + 32'd4;
  endtask

  task automatic drive_c2();
    valid       = 2'b11;
    order[0]    = nxt_order;
    order[1]    = nxt_order + 64'd1;
    inst[0]     = NOP;
    inst[1]     = NOP;
    pc_rdata[0] = nxt_pc;
    pc_wdata[0] = nxt_pc + 32'd4;
    pc_rdata[1] = nxt_pc + 32'd4;
    pc_wdata[1] = nxt_pc + 32'd8;
    nxt_order   = nxt_order + 64'd2;
    nxt_pc      = nxt_pc + 32'd8;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    drive_idle();
    expect_state(tag, 8'h00, 1'b0, 1'b1, 64'd0, 1'b1, 64'd0, 64'd0, 1'b0);
    tick();
    rst       = 1'b0;
    nxt_order = 64'd0;
    nxt_pc    = 32'h1000;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst = 1'b1;
    drive_idle();
    nxt_order = 64'd0;
    nxt_pc    = 32'h1000;

    // Clean dual-lane stream
    do_reset("reset0");
    for (int c = 1; c <= 100; c++) begin
      drive_c2();
      if (c == 1 || c == 50 || c == 100)
        expect_state($sformatf("stream_c%0d", c), 8'h00, 1'b0, 1'b1, 64'd0,
                     1'b1, 64'(2 * c), 64'(c), 1'b0);
      tick();
    end

    // Hole in the valid prefix
    do_reset("reset_pack");
    for (int c = 0; c < 4; c++) begin
      drive_c2();
      tick();
    end
    drive_idle();
    valid       = 2'b10;
    order[1]    = nxt_order;
    pc_rdata[1] = 32'h2000;
    pc_wdata[1] = 32'h2004;
    expect_state("pack_err", 8'h01, 1'b0, 1'b1, 64'd8, 1'b1, 64'd8, 64'd5, 1'b0);
    tick();
    drive_c2();
    expect_state("pack_sticky", 8'h01, 1'b0, 1'b1, 64'd8, 1'b1, 64'd10, 64'd6, 1'b0);
    tick();

    // Order gap then resync
    do_reset("reset_order");
    drive_c2();
    expect_state("order_ok", 8'h00, 1'b0, 1'b1, 64'd0, 1'b0, 64'd0, 64'd0, 1'b0);
    tick();
    nxt_order = 64'd3;
    drive_c2();
    expect_state("order_gap", 8'h02, 1'b0, 1'b1, 64'd3, 1'b0, 64'd0, 64'd0, 1'b0);
    tick();
    drive_c2();
    expect_state("order_resync", 8'h02, 1'b0, 1'b1, 64'd3, 1'b0, 64'd0, 64'd0, 1'b0);
    tick();
    drive_c1(NOP);
    expect_state("order_resync2", 8'h02, 1'b0, 1'b1, 64'd3, 1'b0, 64'd0, 64'd0, 1'b0);
    tick();

    // Halt on lane 0 with lane 1 still committing
    do_reset("reset_halt");
    drive_c2();
    tick();
    valid       = 2'b11;
    order[0]    = 64'd2;
    order[1]    = 64'd3;
    inst[0]     = JALS;
    inst[1]     = NOP;
    pc_rdata[0] = 32'h1008;
    pc_wdata[0] = 32'h1008;
    pc_rdata[1] = 32'h1008;
    pc_wdata[1] = 32'h100c;
    expect_state("halt_posthalt", 8'h10, 1'b1, 1'b1, 64'd3, 1'b0, 64'd0, 64'd0, 1'b0);
    tick();
    drive_idle();
    for (int c = 1; c <= 25; c++) begin
      if (c == 25)
        expect_state("halt_stall_no_timeout", 8'h10, 1'b1, 1'b1, 64'd3, 1'b0, 64'd0, 64'd0, 1'b0);
      tick();
    end

    // Watchdog expiry
    do_reset("reset_tmo");
    drive_c2();
    tick();
    drive_idle();
    for (int c = 1; c <= TMO; c++) begin
      if (c == TMO - 1)
        expect_state("tmo_before", 8'h00, 1'b0, 1'b1, 64'd0, 1'b0, 64'd0, 64'd0, 1'b0);
      if (c == TMO)
        expect_state("tmo_fire", 8'h08, 1'b0, 1'b1, 64'd2, 1'b0, 64'd0, 64'd0, 1'b0);
      tick();
    end

    // Measurement window
    do_reset("reset_win");
    for (int c = 1; c <= 9; c++) begin
      drive_c1(NOP);
      tick();
    end
    drive_c1(START);
    expect_state("win_start", 8'h00, 1'b0, 1'b1, 64'd0, 1'b1, 64'd0, 64'd0, 1'b0);
    tick();
    for (int j = 0; j < 39; j++) begin
      if (j < 30) drive_c1(NOP);
      else        drive_idle();
      tick();
    end
    drive_c1(STOP);
    expect_state("win_stop", 8'h00, 1'b0, 1'b1, 64'd0, 1'b1, 64'd31, 64'd40, 1'b1);
    tick();
    for (int c = 1; c <= 5; c++) begin
      drive_c2();
      if (c == 5)
        expect_state("win_frozen", 8'h00, 1'b0, 1'b1, 64'd0, 1'b1, 64'd31, 64'd40, 1'b1);
      tick();
    end
    rst = 1'b1;
    drive_c2();
    expect_state("mid_run_reset", 8'h00, 1'b0, 1'b1, 64'd0, 1'b1, 64'd0, 64'd0, 1'b0);
    tick();
    rst = 1'b0;
    drive_idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rvfi_commit_checker.md
# rvfi_commit_checker

Parametrised, synthesizable RVFI commit checker for multi-issue cores: accepts NRET retirement lanes per cycle and checks lane packing, the `order` sequence, and PC continuity. It also detects halt, runs a no-commit watchdog, and counts instructions and cycles between the start and stop marker instructions. It sits beside the per-lane formal monitors on the core's RVFI bus and drives the bench's `halt` and `error` signals.

## Interface
- `NRET`, 2: commit lanes per cycle (≥1); lane 0 is oldest.
- `CNT_W`, 64: width of `order`, `inst_count`, `cycle_count`.
- `TIMEOUT`, 10000: cycles without a commit before a timeout error; 0 disables the watchdog.

- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `valid`  in  NRET  per-lane commit strobe
- `order`  in  NRET×CNT_W  per-lane retirement index
- `inst`  in  NRET×32  per-lane instruction word
- `pc_rdata`  in  NRET×32  per-lane PC of the instruction
- `pc_wdata`  in  NRET×32  per-lane next PC
- `halt`  out  1  sticky; halt condition seen
- `error`  out  1  sticky; OR of all `errcode` bits
- `errcode`  out  8  sticky per-class error bits
- `first_err_order`  out  CNT_W  `order` of the lane that raised the first error
- `inst_count`  out  CNT_W  commits counted in the current window
- `cycle_count`  out  CNT_W  cycles counted in the current window
- `window_done`  out  1  stop marker seen; counters frozen

## Operation
- All outputs reset to 0; internal `exp_order` resets to 0, `pc_known` to 0, and the watchdog counter to 0.
- Lane packing:
  - Valid lanes must form a prefix (lanes 0..k-1).
  - Any valid lane above an invalid lane sets `errcode[0]`.
  - The commit count k is the prefix length; a non-prefix valid lane is ignored for the order, PC and count checks.
- Order:
  - Lane i (i<k) requires `order[i] == exp_order + i`; a mismatch sets `errcode[1]`.
  - Then `exp_order <= order[k-1] + 1`. This resynchronises after a mismatch so one gap raises one error, not a cascade.
- PC chain:
  - Lane 0 `pc_rdata` must equal `last_pc`, checked only when `pc_known`.
  - Lane i>0 `pc_rdata` must equal lane i-1 `pc_wdata`.
  - A mismatch sets `errcode[2]`.
  - `last_pc <= pc_wdata[k-1]` and `pc_known <= 1` when k>0.
- Halt:
  - A lane halts if `pc_rdata == pc_wdata`, or `inst` is 0x00000063 or 0x0000006f.
  - A halting lane sets `halt`.
  - Any valid lane after the halting lane in the same cycle, or any commit once `halt` is set, sets `errcode[4]`.
- Watchdog:
  - The counter clears on k>0; otherwise it increments, saturating at `TIMEOUT`.
  - Reaching `TIMEOUT` while `!halt` sets `errcode[3]`; `first_err_order` gets `exp_order`.
  - The watchdog is frozen once `halt` is set.
- `first_err_order`:
  - Captured only on the cycle `error` goes 0→1.
  - Source is the lowest-index offending lane's `order`.
  - Sticky errors never clear except on `rst`.
- Measurement window (start marker `inst == 0x00102013`, stop marker `inst == 0x00202013`):
  - Before any marker, the window is open from reset release.
  - On a start-marker cycle: `cycle_count <= 0`, `inst_count <= 0`, `window_done <= 0`. A stop marker in the same cycle is ignored.
  - Otherwise, while `!window_done`: `cycle_count += 1` and `inst_count += k`.
  - On a stop-marker cycle, the increments (including the marker lane) are applied, then `window_done <= 1`.
- `errcode[7:5]` are reserved and always 0.

## Timing
- Every output is registered: a commit sampled at edge N is reflected at edge N+1.
- `error` rises the same cycle as its `errcode` bit.
- Several error classes in one cycle each set their bit; `first_err_order` uses the lowest offending lane.
- `rst` asserted mid-run clears all state on the next edge; any commits presented during `rst` are ignored.
- Counters do not wrap in practice (64 bits); at CNT_W overflow they wrap modulo 2^CNT_W.
- The watchdog counter is `$clog2(TIMEOUT+1)` bits wide.

## Structure
- Package `rvfi_chk_pkg` holds:
  - `ERR_PACK=0`, `ERR_ORDER=1`, `ERR_PC=2`, `ERR_TIMEOUT=3`, `ERR_POSTHALT=4`
  - `INST_START=32'h00102013`, `INST_STOP=32'h00202013`
  - `INST_BEQ_SELF=32'h00000063`, `INST_JAL_SELF=32'h0000006f`
- Sub-module `rvfi_chk_lane`: purely combinational per-lane classifier.
  - Inputs: `inst`, `pc_rdata`, `pc_wdata`.
  - Outputs: `is_halt`, `is_start`, `is_stop`.
  - Instantiated NRET times via generate.

## Test plan
- NRET=2, 100 cycles committing 2 contiguous lanes with orders 0..199 and a chained PC stepping 4 per instruction → `error`=0, `inst_count`=200, `cycle_count`=100.
- `valid`=2'b10 at cycle 5 → `errcode`=0x01 at cycle 6, `first_err_order` = lane 1 order.
- Orders 0,1 then 3,4 → `errcode[1]` set once; subsequent commits 5,6 raise no further order error.
- Lane 0 committing `inst`=0x0000006f with `pc_rdata == pc_wdata` while lane 1 is also valid → `halt`=1 and `errcode`=0x10 next cycle.
- TIMEOUT=20, stall commits for 20 cycles → `errcode`=0x08 on cycle 21. Same stall after `halt` → no error.
- Start marker at cycle 10, 30 commits over 40 cycles, stop marker at cycle 50 → `inst_count`=31 (includes the stop marker lane), `cycle_count`=40, `window_done`=1, counters frozen afterwards. Assert `rst` at cycle 60 → all outputs 0 at cycle 61.
